// File: rtl/ntsc_sync_pkg.sv
// Timing constants, half-line classification and decode helper for the NTSC sync generator.
// All counts are in 4 MHz ticks (250 ns).
`timescale 1ns/1ps
package ntsc_sync_pkg;

    localparam logic [6:0]  HALF_LINE   = 7'd127;
    localparam logic [10:0] FRAME_HL    = 11'd1050;
    localparam logic [10:0] FIELD2_HL   = 11'd525;

    localparam logic [6:0]  HSYNC_W     = 7'd19;
    localparam logic [6:0]  EQ_W        = 7'd9;
    localparam logic [6:0]  BROAD_LOW   = 7'd108;
    localparam logic [6:0]  BURST_START = 7'd22;
    localparam logic [6:0]  BURST_END   = 7'd31;

    // Field-relative half-line bounds; field 2 uses the same pattern offset by FIELD2_HL.
    localparam logic [10:0] EQ_PRE_HI   = 11'd5;
    localparam logic [10:0] BROAD_LO    = 11'd6;
    localparam logic [10:0] BROAD_HI    = 11'd11;
    localparam logic [10:0] EQ_POST_HI  = 11'd17;

    typedef enum logic [1:0] {
        HL_NORMAL = 2'd0,
        HL_EQ     = 2'd1,
        HL_BROAD  = 2'd2
    } hl_type_e;

    function automatic hl_type_e hl_type(input logic [10:0] hl);
        logic [10:0] hl_f;
        hl_type_e    typ;
        if (hl >= FIELD2_HL) begin
            hl_f = hl - FIELD2_HL;
        end else begin
            hl_f = hl;
        end
        if (hl_f <= EQ_PRE_HI) begin
            typ = HL_EQ;
        end else if (hl_f >= BROAD_LO && hl_f <= BROAD_HI) begin
            typ = HL_BROAD;
        end else if (hl_f <= EQ_POST_HI) begin
            typ = HL_EQ;
        end else begin
            typ = HL_NORMAL;
        end
        return typ;
    endfunction

endpackage

// File: rtl/ntsc_timing_counter.sv
// Tick (0..126) and half-line (0..1049) counters for the NTSC sync generator.
// Both hold their value whenever en is low.
`timescale 1ns/1ps
module ntsc_timing_counter
    import ntsc_sync_pkg::*;
(
    input  logic        clk4mhz,
    input  logic        rst,
    input  logic        en,
    output logic [6:0]  tick,
    output logic [10:0] hl
);

    logic [6:0]  tick_q, tick_d;
    logic [10:0] hl_q, hl_d;

    // Next-count logic with wrap at end of half-line and end of frame.
    always_comb begin
        tick_d = tick_q;
        hl_d   = hl_q;
        if (en) begin
            if (tick_q == HALF_LINE - 7'd1) begin
                tick_d = 7'd0;
                if (hl_q == FRAME_HL - 11'd1) begin
                    hl_d = 11'd0;
                end else begin
                    hl_d = hl_q + 11'd1;
                end
            end else begin
                tick_d = tick_q + 7'd1;
            end
        end else begin
            tick_d = tick_q;
            hl_d   = hl_q;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk4mhz or posedge rst) begin
        if (rst) begin
            tick_q <= 7'd0;
            hl_q   <= 11'd0;
        end else begin
            tick_q <= tick_d;
            hl_q   <= hl_d;
        end
    end

    assign tick = tick_q;
    assign hl   = hl_q;

endmodule

// File: rtl/ntsc_sync_gen.sv
// NTSC composite/vertical sync, burst gate, field/line and start-of-frame generator.
// Outputs are registered decodes of the counter position seen before each clock edge.
`timescale 1ns/1ps
module ntsc_sync_gen
    import ntsc_sync_pkg::*;
(
    input  logic       clk4mhz,
    input  logic       rst,
    input  logic       en,
    output logic       csync,
    output logic       vsync,
    output logic       burst,
    output logic       field,
    output logic [9:0] line,
    output logic       sof
);

    logic [6:0]  tick_s;
    logic [10:0] hl_s;
    hl_type_e    typ_s;
    logic        csync_low_s;
    logic        vsync_low_s;
    logic        burst_low_s;
    logic        even_hl_s;

    logic       csync_q, csync_d;
    logic       vsync_q, vsync_d;
    logic       burst_q, burst_d;
    logic       field_q, field_d;
    logic [9:0] line_q, line_d;
    logic       sof_q, sof_d;

    ntsc_timing_counter u_counter (
        .clk4mhz (clk4mhz),
        .rst     (rst),
        .en      (en),
        .tick    (tick_s),
        .hl      (hl_s)
    );

    // Classify the current half-line and decode the active-high pulse conditions.
    always_comb begin
        typ_s       = hl_type(hl_s);
        even_hl_s   = ~hl_s[0];
        csync_low_s = 1'b0;
        vsync_low_s = 1'b0;
        burst_low_s = 1'b0;
        case (typ_s)
            HL_EQ: begin
                csync_low_s = (tick_s < EQ_W);
            end
            HL_BROAD: begin
                csync_low_s = (tick_s < BROAD_LOW);
                vsync_low_s = 1'b1;
            end
            HL_NORMAL: begin
                // Odd normal half-lines are the second half of a visible line: no sync.
                csync_low_s = even_hl_s && (tick_s < HSYNC_W);
                burst_low_s = even_hl_s && (tick_s >= BURST_START) && (tick_s <= BURST_END);
            end
            default: begin
                csync_low_s = 1'b0;
                vsync_low_s = 1'b0;
                burst_low_s = 1'b0;
            end
        endcase
    end

    // Output next-state: live decode when running, idle levels with held field/line when not.
    always_comb begin
        csync_d = 1'b1;
        vsync_d = 1'b1;
        burst_d = 1'b1;
        field_d = field_q;
        line_d  = line_q;
        sof_d   = 1'b0;
        if (en) begin
            csync_d = ~csync_low_s;
            vsync_d = ~vsync_low_s;
            burst_d = ~burst_low_s;
            field_d = (hl_s < FIELD2_HL);
            line_d  = hl_s[10:1] + 10'd1;
            sof_d   = (hl_s == 11'd0) && (tick_s == 7'd0);
        end else begin
            csync_d = 1'b1;
            vsync_d = 1'b1;
            burst_d = 1'b1;
            field_d = field_q;
            line_d  = line_q;
            sof_d   = 1'b0;
        end
    end

    // Output registers.
    always_ff @(posedge clk4mhz or posedge rst) begin
        if (rst) begin
            csync_q <= 1'b1;
            vsync_q <= 1'b1;
            burst_q <= 1'b1;
            field_q <= 1'b1;
            line_q  <= 10'd1;
            sof_q   <= 1'b0;
        end else begin
            csync_q <= csync_d;
            vsync_q <= vsync_d;
            burst_q <= burst_d;
            field_q <= field_d;
            line_q  <= line_d;
            sof_q   <= sof_d;
        end
    end

    assign csync = csync_q;
    assign vsync = vsync_q;
    assign burst = burst_q;
    assign field = field_q;
    assign line  = line_q;
    assign sof   = sof_q;

endmodule

// File: tb/tb_ntsc_sync_gen.sv
// Directed bench for ntsc_sync_gen: runs field 1 with an enable pause mid-frame,
// then asserts reset inside a field-2 broad pulse. p is the counter position decoded by each edge.
`timescale 1ns/1ps
module tb_ntsc_sync_gen;

    logic       clk4mhz = 1'b0;
    logic       rst;
    logic       en;
    logic       csync;
    logic       vsync;
    logic       burst;
    logic       field;
    logic [9:0] line;
    logic       sof;

    int n_checks = 0;
    int n_err    = 0;
    int p;
    int falls;
    int vlow;
    int sofs;
    int overlap;
    logic prev_cs;
    logic paused;

    ntsc_sync_gen dut (
        .clk4mhz (clk4mhz),
        .rst     (rst),
        .en      (en),
        .csync   (csync),
        .vsync   (vsync),
        .burst   (burst),
        .field   (field),
        .line    (line),
        .sof     (sof)
    );

    always #125 clk4mhz = ~clk4mhz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk4mhz);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_csync"}, {31'd0, csync}, 32'd1);
        chk({tag, "_vsync"}, {31'd0, vsync}, 32'd1);
        chk({tag, "_burst"}, {31'd0, burst}, 32'd1);
        chk({tag, "_sof"},   {31'd0, sof},   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        #10;
        chk_idle("rst0");
        chk("rst0_field", {31'd0, field}, 32'd1);
        chk("rst0_line",  {22'd0, line},  32'd1);
        en = 1'b1;
        step();
        step();
        chk_idle("rst_held");
        chk("rst_held_line", {22'd0, line}, 32'd1);
        rst = 1'b0;

        p       = 0;
        falls   = 0;
        vlow    = 0;
        sofs    = 0;
        overlap = 0;
        prev_cs = 1'b1;
        paused  = 1'b0;

        while (p < 67731) begin
            if (p == 38150 && !paused) begin
                en = 1'b0;
                step();
                chk_idle("pause_first");
                chk("pause_first_line",  {22'd0, line},  32'd151);
                chk("pause_first_field", {31'd0, field}, 32'd1);
                repeat (999) step();
                chk_idle("pause_last");
                chk("pause_last_line", {22'd0, line}, 32'd151);
                en     = 1'b1;
                paused = 1'b1;
            end
            step();
            if (p < 66675) begin
                if (prev_cs && !csync) falls++;
                if (!vsync) vlow++;
            end
            if (!burst && !csync) overlap++;
            if (sof) sofs++;
            prev_cs = csync;
            case (p)
                0: begin
                    chk("p0_csync", {31'd0, csync}, 32'd0);
                    chk("p0_sof",   {31'd0, sof},   32'd1);
                    chk("p0_vsync", {31'd0, vsync}, 32'd1);
                    chk("p0_burst", {31'd0, burst}, 32'd1);
                    chk("p0_field", {31'd0, field}, 32'd1);
                    chk("p0_line",  {22'd0, line},  32'd1);
                end
                8:     chk("eq_last_low",  {31'd0, csync}, 32'd0);
                9: begin
                    chk("eq_high",  {31'd0, csync}, 32'd1);
                    chk("p9_sof",   {31'd0, sof},   32'd0);
                end
                761:   chk("pre_broad_vsync", {31'd0, vsync}, 32'd1);
                762: begin
                    chk("hl6_csync", {31'd0, csync}, 32'd0);
                    chk("hl6_vsync", {31'd0, vsync}, 32'd0);
                end
                869:   chk("hl6_t107_csync", {31'd0, csync}, 32'd0);
                870: begin
                    chk("hl6_t108_csync", {31'd0, csync}, 32'd1);
                    chk("hl6_t108_vsync", {31'd0, vsync}, 32'd0);
                end
                888:   chk("hl6_t126_csync", {31'd0, csync}, 32'd1);
                1523:  chk("hl11_end_vsync", {31'd0, vsync}, 32'd0);
                1524: begin
                    chk("hl12_vsync", {31'd0, vsync}, 32'd1);
                    chk("hl12_csync", {31'd0, csync}, 32'd0);
                end
                2540: begin
                    chk("hl20_csync", {31'd0, csync}, 32'd0);
                    chk("hl20_burst", {31'd0, burst}, 32'd1);
                    chk("hl20_line",  {22'd0, line},  32'd11);
                end
                2558:  chk("hl20_t18_csync", {31'd0, csync}, 32'd0);
                2559:  chk("hl20_t19_csync", {31'd0, csync}, 32'd1);
                2561:  chk("hl20_t21_burst", {31'd0, burst}, 32'd1);
                2562:  chk("hl20_t22_burst", {31'd0, burst}, 32'd0);
                2571:  chk("hl20_t31_burst", {31'd0, burst}, 32'd0);
                2572:  chk("hl20_t32_burst", {31'd0, burst}, 32'd1);
                2667: begin
                    chk("hl21_t0_csync", {31'd0, csync}, 32'd1);
                    chk("hl21_t0_burst", {31'd0, burst}, 32'd1);
                    chk("hl21_line",     {22'd0, line},  32'd11);
                end
                2700: begin
                    chk("hl21_t33_csync", {31'd0, csync}, 32'd1);
                    chk("hl21_t33_burst", {31'd0, burst}, 32'd1);
                end
                38150: begin
                    chk("resume_csync", {31'd0, csync}, 32'd1);
                    chk("resume_line",  {22'd0, line},  32'd151);
                end
                38353: chk("hl301_end_csync", {31'd0, csync}, 32'd1);
                38354: begin
                    chk("hl302_csync", {31'd0, csync}, 32'd0);
                    chk("hl302_line",  {22'd0, line},  32'd152);
                end
                66674: begin
                    chk("f1_end_field", {31'd0, field}, 32'd1);
                    chk("f1_end_line",  {22'd0, line},  32'd263);
                end
                66675: begin
                    chk("f2_start_field", {31'd0, field}, 32'd0);
                    chk("f2_start_line",  {22'd0, line},  32'd263);
                    chk("f2_start_csync", {31'd0, csync}, 32'd0);
                end
                67730: begin
                    chk("hl533_csync", {31'd0, csync}, 32'd0);
                    chk("hl533_vsync", {31'd0, vsync}, 32'd0);
                    chk("hl533_field", {31'd0, field}, 32'd0);
                    chk("hl533_line",  {22'd0, line},  32'd267);
                end
                default: ;
            endcase
            p++;
        end

        chk("field1_csync_falls", falls,   32'd272);
        chk("field1_vsync_low",   vlow,    32'd762);
        chk("burst_overlap",      overlap, 32'd0);
        chk("sof_count",          sofs,    32'd1);

        rst = 1'b1;
        #5;
        chk_idle("midrst");
        chk("midrst_field", {31'd0, field}, 32'd1);
        chk("midrst_line",  {22'd0, line},  32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("midrst_hold");
            chk("midrst_hold_line", {22'd0, line}, 32'd1);
        end
        rst = 1'b0;
        step();
        chk("post_rst_sof",   {31'd0, sof},   32'd1);
        chk("post_rst_csync", {31'd0, csync}, 32'd0);
        chk("post_rst_vsync", {31'd0, vsync}, 32'd1);
        chk("post_rst_field", {31'd0, field}, 32'd1);
        chk("post_rst_line",  {22'd0, line},  32'd1);
        step();
        chk("post_rst2_sof",   {31'd0, sof},   32'd0);
        chk("post_rst2_csync", {31'd0, csync}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
